// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches words over a req/ack handshake and
// presents them to IF/ID, honouring stalls, delayed-slot redirects and exception flushes.
module if_fetch_unit #(
    parameter logic [29:0] RESET_PC   = 30'h0000_0000,
    parameter logic [29:0] EXC_VECTOR = 30'h0000_0200
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        hazard,
    input  logic        Branch_ok,
    input  logic [29:0] branch_target,
    input  logic [1:0]  id_Jump,
    input  logic [29:0] jump_target,
    input  logic        exc_req,
    input  logic        eret_req,
    input  logic [29:0] epc,
    output logic        imem_req,
    output logic [29:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_ins,
    output logic [29:0] PC,
    output logic [29:0] PC_plus_4,
    output logic        fetch_bubble
);

    localparam logic [1:0] ST_REQ  = 2'd0;
    localparam logic [1:0] ST_HOLD = 2'd1;
    localparam logic [1:0] ST_DROP = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [29:0] fetch_pc_q, fetch_pc_d;
    logic        req_q, req_d;
    logic [29:0] addr_q, addr_d;
    logic [31:0] ins_q, ins_d;
    logic [29:0] pc_q, pc_d;
    logic        bubble_q, bubble_d;
    logic        pend_q, pend_d;
    logic [29:0] tgt_q, tgt_d;

    logic        redir_s;
    logic [29:0] redir_tgt_s;
    logic        flush_s;
    logic [29:0] flush_tgt_s;
    logic [29:0] next_pc_s;
    logic        outstanding_s;

    assign redir_s       = Branch_ok | (|id_Jump);
    assign redir_tgt_s   = Branch_ok ? branch_target : jump_target;
    assign flush_s       = exc_req | eret_req;
    assign flush_tgt_s   = exc_req ? EXC_VECTOR : epc;
    // A redirect seen in the accept cycle itself steers the very next fetch.
    assign next_pc_s     = redir_s ? redir_tgt_s : (pend_q ? tgt_q : pc_q + 30'd1);
    assign outstanding_s = (state_q != ST_HOLD) & req_q & ~imem_ack;

    // Next-state logic: handshake sequencing, redirect bookkeeping, flush override.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_d      = req_q;
        addr_d     = addr_q;
        ins_d      = ins_q;
        pc_d       = pc_q;
        bubble_d   = bubble_q;
        pend_d     = pend_q;
        tgt_d      = tgt_q;

        if (redir_s) begin
            pend_d = 1'b1;
            tgt_d  = redir_tgt_s;
        end else begin
            pend_d = pend_q;
        end

        case (state_q)
            ST_REQ: begin
                if (!req_q) begin
                    req_d  = 1'b1;
                    addr_d = fetch_pc_q;
                end else if (imem_ack) begin
                    ins_d    = imem_rdata;
                    pc_d     = addr_q;
                    bubble_d = 1'b0;
                    req_d    = 1'b0;
                    state_d  = ST_HOLD;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_HOLD: begin
                if (!hazard) begin
                    fetch_pc_d = next_pc_s;
                    req_d      = 1'b1;
                    addr_d     = next_pc_s;
                    pend_d     = 1'b0;
                    ins_d      = 32'd0;
                    bubble_d   = 1'b1;
                    state_d    = ST_REQ;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            ST_DROP: begin
                if (imem_ack) begin
                    req_d   = 1'b1;
                    addr_d  = fetch_pc_q;
                    state_d = ST_REQ;
                end else begin
                    state_d = ST_DROP;
                end
            end
            default: begin
                state_d = ST_REQ;
                req_d   = 1'b0;
            end
        endcase

        // Flush overrides everything, but never withdraws a request mid-handshake.
        if (flush_s) begin
            fetch_pc_d = flush_tgt_s;
            pend_d     = 1'b0;
            ins_d      = 32'd0;
            bubble_d   = 1'b1;
            req_d      = 1'b1;
            if (outstanding_s) begin
                state_d = ST_DROP;
                addr_d  = addr_q;
            end else begin
                state_d = ST_REQ;
                addr_d  = flush_tgt_s;
            end
        end else begin
            state_d = state_d;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= ST_REQ;
            fetch_pc_q <= RESET_PC;
            req_q      <= 1'b0;
            addr_q     <= RESET_PC;
            ins_q      <= 32'd0;
            pc_q       <= RESET_PC;
            bubble_q   <= 1'b1;
            pend_q     <= 1'b0;
            tgt_q      <= 30'd0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_q      <= req_d;
            addr_q     <= addr_d;
            ins_q      <= ins_d;
            pc_q       <= pc_d;
            bubble_q   <= bubble_d;
            pend_q     <= pend_d;
            tgt_q      <= tgt_d;
        end
    end

    assign imem_req     = req_q;
    assign imem_addr    = addr_q;
    assign if_ins       = ins_q;
    assign PC           = pc_q;
    assign PC_plus_4    = pc_q + 30'd1;
    assign fetch_bubble = bubble_q;

endmodule
